// File: rtl/pipe_cla_addsub.sv
// Pipelined two's-complement add/subtract with optional saturation.
// Each stage resolves one WIDTH/STAGES slice with nibble CLA logic; slice carries ripple stage to stage.
module pipe_cla_addsub #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [1:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic             Ovfl,
    output logic             pos_Ovfl,
    output logic             neg_Ovfl,
    output logic             Zero
);

    localparam int unsigned SW   = WIDTH / STAGES;
    localparam int unsigned NIB  = SW / 4;
    localparam int unsigned LAST = STAGES - 1;

    // Slice adder: 4-bit lookahead nibbles, nibble group P/G producing the next nibble carry.
    function automatic logic [SW:0] cla_slice(input logic [SW-1:0] a,
                                              input logic [SW-1:0] b,
                                              input logic          cin);
        logic [SW-1:0] s;
        logic [3:0]    p;
        logic [3:0]    g;
        logic [3:0]    c;
        logic          cg;
        s  = '0;
        cg = cin;
        for (int unsigned n = 0; n < NIB; n++) begin
            p    = a[n*4 +: 4] ^ b[n*4 +: 4];
            g    = a[n*4 +: 4] & b[n*4 +: 4];
            c[0] = cg;
            c[1] = g[0] | (p[0] & cg);
            c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cg);
            c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cg);
            s[n*4 +: 4] = p ^ c;
            cg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
               | ((&p) & cg);
        end
        return {cg, s};
    endfunction

    logic             w_advance;
    logic             r_v   [STAGES];
    logic [WIDTH-1:0] r_a   [STAGES];
    logic [WIDTH-1:0] r_b   [STAGES];
    logic [WIDTH-1:0] r_s   [STAGES];
    logic             r_sat [STAGES];
    logic             r_c   [STAGES];

    assign w_advance = ~r_v[LAST] | out_ready;
    assign in_ready  = w_advance;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic             w_v;
        logic             w_cin;
        logic             w_sat;
        logic [WIDTH-1:0] w_a;
        logic [WIDTH-1:0] w_b;
        logic [WIDTH-1:0] w_s_in;
        logic [WIDTH-1:0] w_s;
        logic [SW:0]      w_slice;

        if (k == 0) begin : g_in
            // Subtraction folds into B inversion plus carry-in; only the saturate bit travels on.
            assign w_v    = in_valid;
            assign w_a    = A;
            assign w_b    = mode[0] ? ~B : B;
            assign w_sat  = mode[1];
            assign w_cin  = mode[0];
            assign w_s_in = '0;
        end else begin : g_link
            assign w_v    = r_v[k-1];
            assign w_a    = r_a[k-1];
            assign w_b    = r_b[k-1];
            assign w_sat  = r_sat[k-1];
            assign w_cin  = r_c[k-1];
            assign w_s_in = r_s[k-1];
        end

        assign w_slice = cla_slice(w_a[k*SW +: SW], w_b[k*SW +: SW], w_cin);

        always_comb begin
            w_s = w_s_in;
            w_s[k*SW +: SW] = w_slice[SW-1:0];
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                r_v[k]   <= 1'b0;
                r_a[k]   <= '0;
                r_b[k]   <= '0;
                r_s[k]   <= '0;
                r_sat[k] <= 1'b0;
                r_c[k]   <= 1'b0;
            end else if (w_advance) begin
                r_v[k]   <= w_v;
                r_a[k]   <= w_a;
                r_b[k]   <= w_b;
                r_s[k]   <= w_s;
                r_sat[k] <= w_sat;
                r_c[k]   <= w_slice[SW];
            end
        end
    end

    logic w_pos;
    logic w_neg;

    assign w_pos     = ~r_a[LAST][WIDTH-1] & ~r_b[LAST][WIDTH-1] &  r_s[LAST][WIDTH-1];
    assign w_neg     =  r_a[LAST][WIDTH-1] &  r_b[LAST][WIDTH-1] & ~r_s[LAST][WIDTH-1];
    assign pos_Ovfl  = w_pos;
    assign neg_Ovfl  = w_neg;
    assign Ovfl      = w_pos | w_neg;
    assign Cout      = r_c[LAST];
    assign out_valid = r_v[LAST];

    always_comb begin
        Sum = r_s[LAST];
        if (r_sat[LAST] && w_pos) begin
            Sum = {1'b0, {(WIDTH-1){1'b1}}};
        end else if (r_sat[LAST] && w_neg) begin
            Sum = {1'b1, {(WIDTH-1){1'b0}}};
        end
    end

    // Gated by valid so the cleared post-reset state reports Zero=0.
    assign Zero = r_v[LAST] & (Sum == '0);

endmodule

// File: tb/tb_pipe_cla_addsub.sv
// Randomized and directed checks of pipe_cla_addsub against a signed-arithmetic reference model.
module tb_pipe_cla_addsub;

    localparam int unsigned W = 16;
    localparam int unsigned S = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  A;
    logic [W-1:0]  B;
    logic [1:0]    mode;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  Sum;
    logic          Cout;
    logic          Ovfl;
    logic          pos_Ovfl;
    logic          neg_Ovfl;
    logic          Zero;

    int unsigned   n_tests = 0;
    int unsigned   n_fail  = 0;
    logic [20:0]   exp_q[$];

    always #5 clk = ~clk;

    pipe_cla_addsub #(.WIDTH(W), .STAGES(S)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .mode(mode), .out_valid(out_valid), .out_ready(out_ready),
        .Sum(Sum), .Cout(Cout), .Ovfl(Ovfl), .pos_Ovfl(pos_Ovfl),
        .neg_Ovfl(neg_Ovfl), .Zero(Zero)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Packed as {Sum, Cout, Ovfl, pos_Ovfl, neg_Ovfl, Zero}.
    function automatic logic [20:0] dut_out();
        return {Sum, Cout, Ovfl, pos_Ovfl, neg_Ovfl, Zero};
    endfunction

    function automatic logic [20:0] model(input logic [15:0] a, input logic [15:0] b,
                                          input logic [1:0] m);
        int          sa;
        int          sb;
        int          r;
        logic [31:0] rv;
        logic        pos;
        logic        neg;
        logic        cout;
        logic [15:0] s;
        sa   = $signed(a);
        sb   = $signed(b);
        r    = m[0] ? sa - sb : sa + sb;
        pos  = r > 32767;
        neg  = r < -32768;
        cout = m[0] ? (a >= b) : ((int'(a) + int'(b)) > 65535);
        rv   = r;
        s    = rv[15:0];
        if (m[1] && pos) s = 16'h7FFF;
        if (m[1] && neg) s = 16'h8000;
        return {s, cout, pos | neg, pos, neg, s == 16'h0000};
    endfunction

    function automatic logic [15:0] rnd_op();
        case ($urandom_range(0, 7))
            0:       return 16'h7FFF;
            1:       return 16'h8000;
            2:       return 16'hFFFF;
            3:       return 16'h0000;
            4:       return 16'h0001;
            default: return 16'($urandom);
        endcase
    endfunction

    // Called at a falling edge with inputs already driven; scores the coming rising edge.
    task automatic tick();
        logic [20:0] e;
        #1;
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("spurious_out", {31'd0, out_valid}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("result", {11'd0, dut_out()}, {11'd0, e});
            end
        end
        if (in_valid && in_ready) exp_q.push_back(model(A, B, mode));
        @(negedge clk);
    endtask

    task automatic directed(input string tag, input logic [15:0] a, input logic [15:0] b,
                            input logic [1:0] m, input logic [20:0] exp);
        A = a; B = b; mode = m; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        check({tag, "_early"}, {31'd0, out_valid}, 32'd0);
        tick();
        check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        check(tag, {11'd0, dut_out()}, {11'd0, exp});
        tick();
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; A = '0; B = '0; mode = 2'b00;
        @(negedge clk);
        tick();
        tick();
        rst = 1'b0;
        check("rst_outputs", {11'd0, dut_out()}, 32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);

        directed("pos_wrap", 16'h7FFF, 16'h0001, 2'b00, {16'h8000, 5'b01100});
        directed("pos_sat",  16'h7FFF, 16'h0001, 2'b10, {16'h7FFF, 5'b01100});
        directed("neg_sat",  16'h8000, 16'h0001, 2'b11, {16'h8000, 5'b11010});
        directed("neg_wrap", 16'h8000, 16'h0001, 2'b01, {16'h7FFF, 5'b11010});
        directed("slice_c",  16'h00FF, 16'h0001, 2'b00, {16'h0100, 5'b00000});
        directed("sub_zero", 16'h1234, 16'h1234, 2'b01, {16'h0000, 5'b10001});
        directed("add_wrap0", 16'hFFFF, 16'h0001, 2'b00, {16'h0000, 5'b10001});

        // Back-to-back inputs, consumer stalls from the third cycle.
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            A = rnd_op(); B = rnd_op(); mode = 2'($urandom_range(0, 3)); in_valid = 1'b1;
            if (i >= 2) out_ready = 1'b0;
            tick();
        end
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("stall_in_ready", {31'd0, in_ready}, 32'd0);
            check("stall_hold", {11'd0, dut_out()}, {11'd0, exp_q[0]});
            tick();
        end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        check("stall_drain", exp_q.size(), 32'd0);

        // Reset with two operations in flight.
        out_ready = 1'b0; in_valid = 1'b1;
        A = 16'h1111; B = 16'h2222; mode = 2'b00; tick();
        A = 16'h3333; B = 16'h0001; mode = 2'b01; tick();
        in_valid = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_q.delete();
        check("flush_outputs", {11'd0, dut_out()}, 32'd0);
        check("flush_out_valid", {31'd0, out_valid}, 32'd0);
        check("flush_in_ready", {31'd0, in_ready}, 32'd1);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("flush_no_stale", {31'd0, out_valid}, 32'd0);
        end

        // Random sweep with random handshakes on both sides.
        for (int i = 0; i < 20000; i++) begin
            in_valid  = ($urandom_range(0, 99) < 70);
            out_ready = ($urandom_range(0, 99) < 75);
            A = rnd_op(); B = rnd_op(); mode = 2'($urandom_range(0, 3));
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
        check("final_drain", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
